// File: rtl/dma_pkg.sv
// Shared types and helpers for the DDR3 traffic initiator.
// Command codes, FSM states and the beat pattern generator.
package dma_pkg;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_CAL,
        ST_WR_REQ,
        ST_WR_DATA,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_NEXT,
        ST_FINISH
    } state_t;

    // One 32-bit lane of the beat pattern; beats replicate it across the bus.
    function automatic logic [31:0] pat_word(
        input logic [15:0] loop,
        input logic [15:0] beat
    );
        return {loop, beat};
    endfunction

endpackage

// File: rtl/dma_rd_checker.sv
// Read-back checker: counts returned beats and compares each one
// with the expected pattern, keeping a saturating mismatch count.
module dma_rd_checker
    import dma_pkg::*;
#(
    parameter int DATA_W    = 256,
    parameter int BURST_LEN = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_run_i,
    input  logic              clr_beat_i,
    input  logic              en_i,
    input  logic [15:0]       loop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              last_o,
    output logic [15:0]       err_cnt_o
);

    localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

    logic [7:0]        beat_q, beat_d;
    logic [15:0]       err_q, err_d;
    logic [DATA_W-1:0] exp_beat;
    logic              mismatch;

    assign exp_beat  = {(DATA_W/32){pat_word(loop_i, {8'h00, beat_q})}};
    assign mismatch  = (data_i != exp_beat);
    assign last_o    = en_i && (beat_q == LAST_BEAT);
    assign err_cnt_o = err_q;

    // Next beat index and saturating error count.
    always_comb begin
        beat_d = beat_q;
        err_d  = err_q;
        if (clr_run_i) begin
            beat_d = '0;
            err_d  = '0;
        end else if (clr_beat_i) begin
            beat_d = '0;
        end else if (en_i) begin
            beat_d = beat_q + 8'd1;
            if (mismatch && (err_q != 16'hFFFF))
                err_d = err_q + 16'd1;
        end
    end

    // Checker state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_q <= '0;
            err_q  <= '0;
        end else begin
            beat_q <= beat_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: rtl/dma_traffic_initiator.sv
// DDR3 traffic initiator: write a patterned burst, read it back,
// compare, and repeat while tracking loops, errors and watchdog.
module dma_traffic_initiator
    import dma_pkg::*;
#(
    parameter int                ADDR_W      = 28,
    parameter int                DATA_W      = 256,
    parameter int                BURST_LEN   = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 28'h0,
    parameter int                ADDR_STEP   = 512,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT  = 28'h0800000,
    parameter int                NUM_LOOPS   = 16,
    parameter int                TIMEOUT_CYC = 65535
) (
    input  logic                I_Clk,
    input  logic                I_Rst,
    input  logic                I_Start,
    input  logic                I_Stop,
    input  logic                I_Calib_Done,
    output logic                O_wr_start,
    output logic [ADDR_W-1:0]   O_wr_addr,
    output logic [2:0]          O_wr_cmd,
    output logic [7:0]          O_wr_burst_len,
    output logic [DATA_W-1:0]   O_wr_data,
    output logic [DATA_W/8-1:0] O_wr_wdf_mask,
    input  logic                I_wr_burst_start,
    input  logic                I_wr_burst_end,
    input  logic                I_wr_rd_en,
    output logic                O_rd_start,
    output logic [ADDR_W-1:0]   O_rd_addr,
    output logic [2:0]          O_rd_cmd,
    output logic [7:0]          O_rd_burst_len,
    input  logic [DATA_W-1:0]   I_rd_data,
    input  logic                I_rd_wr_en,
    output logic                O_Busy,
    output logic                O_Done,
    output logic                O_Pass,
    output logic [15:0]         O_Err_Cnt,
    output logic [15:0]         O_Loop_Cnt,
    output logic                O_Proto_Err,
    output logic                O_Timeout
);

    localparam logic [7:0]    LEN8    = 8'(BURST_LEN);
    localparam logic [15:0]   NLOOPS  = 16'(NUM_LOOPS);
    localparam logic [ADDR_W:0] STEP_X  = (ADDR_W+1)'(ADDR_STEP);
    localparam logic [ADDR_W:0] LIMIT_X = {1'b0, ADDR_LIMIT};
    localparam logic [31:0]   TO_X    = 32'(TIMEOUT_CYC);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          wr_beat_q, wr_beat_d;
    logic [15:0]         loop_q, loop_d;
    logic [31:0]         wd_q, wd_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                proto_q, proto_d;
    logic                to_q, to_d;
    logic                clr_run, clr_beat;
    logic                chk_en, chk_last;
    logic [15:0]         err_cnt;
    logic [ADDR_W:0]     addr_sum;
    logic                wr_room, wd_hit;
    logic                unused_burst_start;

    assign unused_burst_start = I_wr_burst_start;

    assign wr_room  = (wr_beat_q < LEN8);
    assign wd_hit   = (wd_q >= TO_X);
    assign addr_sum = {1'b0, addr_q} + STEP_X;
    assign chk_en   = (state_q == ST_RD_DATA) && I_rd_wr_en;

    dma_rd_checker #(
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN)
    ) u_chk (
        .clk_i      (I_Clk),
        .rst_i      (I_Rst),
        .clr_run_i  (clr_run),
        .clr_beat_i (clr_beat),
        .en_i       (chk_en),
        .loop_i     (loop_q),
        .data_i     (I_rd_data),
        .last_o     (chk_last),
        .err_cnt_o  (err_cnt)
    );

    // Sequencer next-state, flag updates and watchdog.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_beat_d = wr_beat_q;
        loop_d    = loop_q;
        done_d    = done_q;
        pass_d    = pass_q;
        proto_d   = proto_q;
        to_d      = to_q;
        clr_run   = 1'b0;
        clr_beat  = 1'b0;

        if (I_rd_wr_en && (state_q != ST_RD_DATA))
            proto_d = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (I_Start) begin
                    state_d = ST_WAIT_CAL;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    proto_d = 1'b0;
                    to_d    = 1'b0;
                    loop_d  = '0;
                    addr_d  = BASE_ADDR;
                    clr_run = 1'b1;
                end
            end
            ST_WAIT_CAL: begin
                if (I_Calib_Done)
                    state_d = ST_WR_REQ;
            end
            ST_WR_REQ: begin
                wr_beat_d = '0;
                clr_beat  = 1'b1;
                state_d   = ST_WR_DATA;
            end
            ST_WR_DATA: begin
                if (I_wr_rd_en && wr_room)
                    wr_beat_d = wr_beat_q + 8'd1;
                if (I_wr_rd_en && !wr_room)
                    proto_d = 1'b1;
                if (I_wr_burst_end) begin
                    if (wr_beat_d == LEN8) begin
                        state_d = ST_RD_REQ;
                    end else begin
                        proto_d = 1'b1;
                        state_d = ST_FINISH;
                    end
                end else if (wd_hit) begin
                    to_d    = 1'b1;
                    state_d = ST_FINISH;
                end
            end
            ST_RD_REQ: begin
                state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (chk_last) begin
                    state_d = ST_NEXT;
                end else if (wd_hit) begin
                    to_d    = 1'b1;
                    state_d = ST_FINISH;
                end
            end
            ST_NEXT: begin
                loop_d = loop_q + 16'd1;
                addr_d = (addr_sum >= LIMIT_X) ? BASE_ADDR
                                               : addr_sum[ADDR_W-1:0];
                if (I_Stop || ((NUM_LOOPS != 0) && (loop_d == NLOOPS)))
                    state_d = ST_FINISH;
                else
                    state_d = ST_WR_REQ;
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                pass_d  = (err_cnt == 16'd0) && !proto_q && !to_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (I_wr_rd_en || I_wr_burst_end || I_rd_wr_en ||
            (state_d != state_q))
            wd_d = '0;
        else if (wd_q != 32'hFFFF_FFFF)
            wd_d = wd_q + 32'd1;
        else
            wd_d = wd_q;
    end

    // Sequencer registers with synchronous reset.
    always_ff @(posedge I_Clk) begin
        if (I_Rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wr_beat_q <= '0;
            loop_q    <= '0;
            wd_q      <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            proto_q   <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_beat_q <= wr_beat_d;
            loop_q    <= loop_d;
            wd_q      <= wd_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            proto_q   <= proto_d;
            to_q      <= to_d;
        end
    end

    assign O_wr_start     = (state_q == ST_WR_REQ);
    assign O_wr_addr      = O_wr_start ? addr_q : '0;
    assign O_wr_cmd       = O_wr_start ? CMD_WR : 3'b000;
    assign O_wr_burst_len = O_wr_start ? LEN8 : 8'd0;
    assign O_wr_wdf_mask  = '0;
    assign O_wr_data      = ((state_q == ST_WR_DATA) && wr_room)
                          ? {(DATA_W/32){pat_word(loop_q, {8'h00, wr_beat_q})}}
                          : '0;

    assign O_rd_start     = (state_q == ST_RD_REQ);
    assign O_rd_addr      = O_rd_start ? addr_q : '0;
    assign O_rd_cmd       = O_rd_start ? CMD_RD : 3'b000;
    assign O_rd_burst_len = O_rd_start ? LEN8 : 8'd0;

    assign O_Busy      = (state_q != ST_IDLE);
    assign O_Done      = done_q;
    assign O_Pass      = pass_q;
    assign O_Err_Cnt   = err_cnt;
    assign O_Loop_Cnt  = loop_q;
    assign O_Proto_Err = proto_q;
    assign O_Timeout   = to_q;

endmodule
